// File: rtl/sum_engine_arbiter.sv
// Round-robin shares one FP sum engine among workers; tags beats with the worker id and routes results back by tag.
// Issue is one registered stage at 1 beat/cycle; returns are combinational, and a stalled owner stalls the engine.
module sum_engine_arbiter #(
  parameter int NUM_WORKERS     = 4,
  parameter int TID_WIDTH       = 8,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                      clock_i,
  input  logic                      reset_ni,
  input  logic [NUM_WORKERS*64-1:0] req_tdata_i,
  input  logic [NUM_WORKERS-1:0]    req_tvalid_i,
  output logic [NUM_WORKERS-1:0]    req_tready_o,
  output logic [NUM_WORKERS*32-1:0] rsp_tdata_o,
  output logic [NUM_WORKERS-1:0]    rsp_tvalid_o,
  input  logic [NUM_WORKERS-1:0]    rsp_tready_i,
  output logic [31:0]               sum_a_tdata_o,
  output logic [31:0]               sum_b_tdata_o,
  output logic [TID_WIDTH-1:0]      sum_tuser_o,
  output logic                      sum_tvalid_o,
  input  logic                      sum_tready_i,
  input  logic [31:0]               res_tdata_i,
  input  logic [TID_WIDTH-1:0]      res_tuser_i,
  input  logic                      res_tvalid_i,
  output logic                      res_tready_o,
  output logic                      busy_o,
  output logic                      error_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int PW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam logic [CW-1:0] CRED_MAX = CW'(MAX_OUTSTANDING);

  logic                 r_vld;
  logic [31:0]          r_a;
  logic [31:0]          r_b;
  logic [TID_WIDTH-1:0] r_tuser;
  logic [PW-1:0]        r_ptr;
  logic [CW-1:0]        r_cnt [NUM_WORKERS];
  logic                 r_err;

  logic                   w_load_en;
  logic                   w_gnt_vld;
  logic [PW-1:0]          w_gnt_idx;
  logic [63:0]            w_gnt_dat;
  logic [NUM_WORKERS-1:0] w_elig;
  logic [NUM_WORKERS-1:0] w_res_hs;
  logic                   w_res_in_range;
  logic                   w_any_cred;

  assign w_load_en = ~r_vld | sum_tready_i;

  always_comb begin
    w_any_cred = 1'b0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      w_elig[k]  = req_tvalid_i[k] && (r_cnt[k] < CRED_MAX);
      w_any_cred = w_any_cred | (r_cnt[k] != '0);
    end
  end

  // Scan from the pointer, wrapping once, and take the first eligible worker.
  always_comb begin
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_gnt_dat = '0;
    for (int i = 0; i < NUM_WORKERS; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_WORKERS) idx = idx - NUM_WORKERS;
      if (!w_gnt_vld && w_elig[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = PW'(idx);
        w_gnt_dat = req_tdata_i[idx*64 +: 64];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_WORKERS; k++)
      req_tready_o[k] = reset_ni && w_load_en && w_gnt_vld && (w_gnt_idx == PW'(k));
  end

  // Tags outside the worker range are swallowed so the engine never wedges on them.
  always_comb begin
    rsp_tvalid_o   = '0;
    res_tready_o   = 1'b1;
    w_res_in_range = 1'b0;
    for (int k = 0; k < NUM_WORKERS; k++) begin
      if (res_tuser_i == TID_WIDTH'(k)) begin
        w_res_in_range  = 1'b1;
        rsp_tvalid_o[k] = res_tvalid_i;
        res_tready_o    = rsp_tready_i[k];
      end
    end
  end

  assign w_res_hs    = rsp_tvalid_o & rsp_tready_i;
  assign rsp_tdata_o = {NUM_WORKERS{res_tdata_i}};

  always_ff @(posedge clock_i) begin
    if (!reset_ni) begin
      r_vld   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_tuser <= '0;
      r_ptr   <= '0;
      r_err   <= 1'b0;
      for (int k = 0; k < NUM_WORKERS; k++) r_cnt[k] <= '0;
    end else begin
      if (w_load_en) begin
        if (w_gnt_vld) begin
          r_vld   <= 1'b1;
          r_a     <= w_gnt_dat[63:32];
          r_b     <= w_gnt_dat[31:0];
          r_tuser <= TID_WIDTH'(w_gnt_idx);
          r_ptr   <= (w_gnt_idx == PW'(NUM_WORKERS - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else begin
          r_vld <= 1'b0;
        end
      end
      for (int k = 0; k < NUM_WORKERS; k++) begin
        case ({req_tready_o[k], w_res_hs[k]})
          2'b10:   r_cnt[k] <= r_cnt[k] + 1'b1;
          2'b01:   if (r_cnt[k] != '0) r_cnt[k] <= r_cnt[k] - 1'b1;
          default: ;
        endcase
        if (w_res_hs[k] && (r_cnt[k] == '0)) r_err <= 1'b1;
      end
      if (res_tvalid_i && !w_res_in_range) r_err <= 1'b1;
    end
  end

  assign sum_tvalid_o  = r_vld;
  assign sum_a_tdata_o = r_a;
  assign sum_b_tdata_o = r_b;
  assign sum_tuser_o   = r_tuser;
  assign busy_o        = r_vld | w_any_cred;
  assign error_o       = r_err;

endmodule

// File: tb/tb_sum_engine_arbiter.sv
// Directed bench for sum_engine_arbiter with four workers and 16 credits each.
module tb_sum_engine_arbiter;
  logic         clock_i = 1'b0;
  logic         reset_ni;
  logic [255:0] req_tdata_i;
  logic [3:0]   req_tvalid_i;
  logic [3:0]   req_tready_o;
  logic [127:0] rsp_tdata_o;
  logic [3:0]   rsp_tvalid_o;
  logic [3:0]   rsp_tready_i;
  logic [31:0]  sum_a_tdata_o;
  logic [31:0]  sum_b_tdata_o;
  logic [7:0]   sum_tuser_o;
  logic         sum_tvalid_o;
  logic         sum_tready_i;
  logic [31:0]  res_tdata_i;
  logic [7:0]   res_tuser_i;
  logic         res_tvalid_i;
  logic         res_tready_o;
  logic         busy_o;
  logic         error_o;

  int checks = 0;
  int errors = 0;

  sum_engine_arbiter #(.NUM_WORKERS(4), .TID_WIDTH(8), .MAX_OUTSTANDING(16)) dut (
    .clock_i(clock_i), .reset_ni(reset_ni),
    .req_tdata_i(req_tdata_i), .req_tvalid_i(req_tvalid_i), .req_tready_o(req_tready_o),
    .rsp_tdata_o(rsp_tdata_o), .rsp_tvalid_o(rsp_tvalid_o), .rsp_tready_i(rsp_tready_i),
    .sum_a_tdata_o(sum_a_tdata_o), .sum_b_tdata_o(sum_b_tdata_o), .sum_tuser_o(sum_tuser_o),
    .sum_tvalid_o(sum_tvalid_o), .sum_tready_i(sum_tready_i),
    .res_tdata_i(res_tdata_i), .res_tuser_i(res_tuser_i), .res_tvalid_i(res_tvalid_i),
    .res_tready_o(res_tready_o), .busy_o(busy_o), .error_o(error_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic set_pattern_data();
    for (int k = 0; k < 4; k++)
      req_tdata_i[k*64 +: 64] = {32'h1000_0000 + 32'(k), 32'hA000_0000 + 32'(k)};
  endtask

  task automatic do_reset();
    reset_ni     = 1'b0;
    req_tvalid_i = 4'b0000;
    res_tvalid_i = 1'b0;
    sum_tready_i = 1'b1;
    rsp_tready_i = 4'b1111;
    tick();
    tick();
    reset_ni = 1'b1;
  endtask

  task automatic test_reset();
    reset_ni     = 1'b0;
    req_tvalid_i = 4'b1111;
    tick();
    tick();
    checks++; if (req_tready_o !== 4'b0000) begin errors++; $display("FAIL rst_rdy got %b exp 0000", req_tready_o); end
    checks++; if (sum_tvalid_o !== 1'b0) begin errors++; $display("FAIL rst_vld got %b exp 0", sum_tvalid_o); end
    checks++; if ({sum_a_tdata_o, sum_b_tdata_o, sum_tuser_o} !== 72'h0) begin errors++; $display("FAIL rst_data got %h %h %h exp 0", sum_a_tdata_o, sum_b_tdata_o, sum_tuser_o); end
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", error_o); end
    req_tvalid_i = 4'b0000;
    reset_ni     = 1'b1;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    req_tdata_i[63:0] = {32'h3F80_0000, 32'h4000_0000};
    req_tvalid_i      = 4'b0001;
    #1;
    checks++; if (req_tready_o !== 4'b0001) begin errors++; $display("FAIL single_rdy got %b exp 0001", req_tready_o); end
    tick();
    req_tvalid_i = 4'b0000;
    checks++; if (sum_tvalid_o !== 1'b1) begin errors++; $display("FAIL single_vld got %b exp 1", sum_tvalid_o); end
    checks++; if (sum_a_tdata_o !== 32'h3F80_0000) begin errors++; $display("FAIL single_a got %h exp 3f800000", sum_a_tdata_o); end
    checks++; if (sum_b_tdata_o !== 32'h4000_0000) begin errors++; $display("FAIL single_b got %h exp 40000000", sum_b_tdata_o); end
    checks++; if (sum_tuser_o !== 8'd0) begin errors++; $display("FAIL single_tuser got %0d exp 0", sum_tuser_o); end
    tick();
    checks++; if (sum_tvalid_o !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", sum_tvalid_o); end
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL single_busy1 got %b exp 1", busy_o); end
    res_tdata_i  = 32'h4040_0000;
    res_tuser_i  = 8'd0;
    res_tvalid_i = 1'b1;
    #1;
    checks++; if (rsp_tvalid_o !== 4'b0001) begin errors++; $display("FAIL single_rsp_vld got %b exp 0001", rsp_tvalid_o); end
    checks++; if (rsp_tdata_o[31:0] !== 32'h4040_0000 || rsp_tdata_o[127:96] !== 32'h4040_0000) begin errors++; $display("FAIL single_rsp_dat got %h exp 40400000 on every lane", rsp_tdata_o); end
    checks++; if (res_tready_o !== 1'b1) begin errors++; $display("FAIL single_res_rdy got %b exp 1", res_tready_o); end
    tick();
    res_tvalid_i = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL single_busy0 got %b exp 0", busy_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", error_o); end
  endtask

  task automatic test_round_robin();
    do_reset();
    set_pattern_data();
    req_tvalid_i = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (req_tready_o !== (4'b0001 << (i % 4))) begin errors++; $display("FAIL rr_rdy[%0d] got %b exp %b", i, req_tready_o, 4'b0001 << (i % 4)); end
      tick();
      checks++; if (sum_tuser_o !== 8'(i % 4) || sum_tvalid_o !== 1'b1) begin errors++; $display("FAIL rr_tuser[%0d] got %0d/%b exp %0d/1", i, sum_tuser_o, sum_tvalid_o, i % 4); end
      checks++; if (sum_a_tdata_o !== 32'h1000_0000 + 32'(i % 4) || sum_b_tdata_o !== 32'hA000_0000 + 32'(i % 4)) begin errors++; $display("FAIL rr_data[%0d] got %h %h", i, sum_a_tdata_o, sum_b_tdata_o); end
    end
    req_tvalid_i = 4'b0000;
    tick();
  endtask

  task automatic test_back_pressure();
    do_reset();
    set_pattern_data();
    req_tvalid_i = 4'b1111;
    tick();
    sum_tready_i = 1'b0;
    #1;
    checks++; if (req_tready_o !== 4'b0000) begin errors++; $display("FAIL bp_rdy_full got %b exp 0000", req_tready_o); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if (sum_tvalid_o !== 1'b1 || sum_tuser_o !== 8'd0 || sum_a_tdata_o !== 32'h1000_0000 || sum_b_tdata_o !== 32'hA000_0000) begin errors++; $display("FAIL bp_hold[%0d] got %b %0d %h %h exp 1 0 10000000 a0000000", i, sum_tvalid_o, sum_tuser_o, sum_a_tdata_o, sum_b_tdata_o); end
      checks++; if (req_tready_o !== 4'b0000) begin errors++; $display("FAIL bp_rdy[%0d] got %b exp 0000", i, req_tready_o); end
    end
    sum_tready_i = 1'b1;
    #1;
    checks++; if (req_tready_o !== 4'b0010) begin errors++; $display("FAIL bp_release_rdy got %b exp 0010", req_tready_o); end
    tick();
    checks++; if (sum_tuser_o !== 8'd1 || sum_a_tdata_o !== 32'h1000_0001) begin errors++; $display("FAIL bp_next got %0d %h exp 1 10000001", sum_tuser_o, sum_a_tdata_o); end
    checks++; if (req_tready_o !== 4'b0100) begin errors++; $display("FAIL bp_resume_rdy got %b exp 0100", req_tready_o); end
    req_tvalid_i = 4'b0000;
    tick();
  endtask

  task automatic test_credit_limit();
    int seq_b [6] = '{2, 3, 0, 2, 3, 0};
    int seq_d [8] = '{3, 0, 1, 2, 3, 0, 2, 3};
    do_reset();
    set_pattern_data();
    req_tvalid_i = 4'b0010;
    for (int i = 0; i < 16; i++) begin
      #1;
      checks++; if (req_tready_o !== 4'b0010) begin errors++; $display("FAIL cred_fill[%0d] got %b exp 0010", i, req_tready_o); end
      tick();
    end
    #1;
    checks++; if (req_tready_o !== 4'b0000) begin errors++; $display("FAIL cred_full got %b exp 0000", req_tready_o); end
    req_tvalid_i = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      #1;
      checks++; if (req_tready_o !== (4'b0001 << seq_b[i])) begin errors++; $display("FAIL cred_skip[%0d] got %b exp %b", i, req_tready_o, 4'b0001 << seq_b[i]); end
      tick();
    end
    res_tdata_i  = 32'h0000_0001;
    res_tuser_i  = 8'd1;
    res_tvalid_i = 1'b1;
    #1;
    checks++; if (rsp_tvalid_o !== 4'b0010 || res_tready_o !== 1'b1) begin errors++; $display("FAIL cred_ret got %b/%b exp 0010/1", rsp_tvalid_o, res_tready_o); end
    checks++; if (req_tready_o !== 4'b0100) begin errors++; $display("FAIL cred_ret_rdy got %b exp 0100", req_tready_o); end
    tick();
    res_tvalid_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++; if (req_tready_o !== (4'b0001 << seq_d[i])) begin errors++; $display("FAIL cred_once[%0d] got %b exp %b", i, req_tready_o, 4'b0001 << seq_d[i]); end
      tick();
    end
    req_tvalid_i = 4'b0000;
    tick();
  endtask

  task automatic test_return_stall();
    do_reset();
    set_pattern_data();
    req_tvalid_i = 4'b0100;
    tick();
    req_tvalid_i = 4'b0000;
    tick();
    rsp_tready_i = 4'b1011;
    res_tdata_i  = 32'h1234_5678;
    res_tuser_i  = 8'd2;
    res_tvalid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (res_tready_o !== 1'b0 || rsp_tvalid_o !== 4'b0100) begin errors++; $display("FAIL stall[%0d] got %b/%b exp 0/0100", i, res_tready_o, rsp_tvalid_o); end
      tick();
    end
    rsp_tready_i = 4'b1111;
    #1;
    checks++; if (res_tready_o !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", res_tready_o); end
    tick();
    res_tvalid_i = 1'b0;
    tick();
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL stall_busy got %b exp 0", busy_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL stall_err got %b exp 0", error_o); end
  endtask

  task automatic test_error_reset();
    do_reset();
    set_pattern_data();
    req_tvalid_i = 4'b0111;
    tick();
    tick();
    tick();
    req_tvalid_i = 4'b0000;
    tick();
    checks++; if (busy_o !== 1'b1 || sum_tvalid_o !== 1'b0) begin errors++; $display("FAIL err_busy got %b/%b exp 1/0", busy_o, sum_tvalid_o); end
    res_tdata_i  = 32'hDEAD_BEEF;
    res_tuser_i  = 8'd7;
    res_tvalid_i = 1'b1;
    rsp_tready_i = 4'b0000;
    #1;
    checks++; if (res_tready_o !== 1'b1 || rsp_tvalid_o !== 4'b0000) begin errors++; $display("FAIL err_drop got %b/%b exp 1/0000", res_tready_o, rsp_tvalid_o); end
    checks++; if (error_o !== 1'b0) begin errors++; $display("FAIL err_early got %b exp 0", error_o); end
    tick();
    res_tvalid_i = 1'b0;
    rsp_tready_i = 4'b1111;
    checks++; if (error_o !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", error_o); end
    tick();
    checks++; if (error_o !== 1'b1 || busy_o !== 1'b1) begin errors++; $display("FAIL err_sticky got %b/%b exp 1/1", error_o, busy_o); end
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
    checks++; if (sum_tvalid_o !== 1'b0 || error_o !== 1'b0 || busy_o !== 1'b0) begin errors++; $display("FAIL err_clear got %b/%b/%b exp 0/0/0", sum_tvalid_o, error_o, busy_o); end
    res_tuser_i  = 8'd0;
    res_tvalid_i = 1'b1;
    #1;
    checks++; if (res_tready_o !== 1'b1 || rsp_tvalid_o !== 4'b0001) begin errors++; $display("FAIL late_ret got %b/%b exp 1/0001", res_tready_o, rsp_tvalid_o); end
    tick();
    res_tvalid_i = 1'b0;
    checks++; if (error_o !== 1'b1 || busy_o !== 1'b0) begin errors++; $display("FAIL late_underflow got %b/%b exp 1/0", error_o, busy_o); end
    do_reset();
  endtask

  initial begin
    reset_ni     = 1'b0;
    req_tdata_i  = '0;
    req_tvalid_i = '0;
    rsp_tready_i = 4'b1111;
    sum_tready_i = 1'b1;
    res_tdata_i  = '0;
    res_tuser_i  = '0;
    res_tvalid_i = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_credit_limit();
    test_return_stall();
    test_error_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
